// File: rtl/msl_slave_receiver.sv
// MSL single-wire line decoder: classifies segment widths as short/long and rebuilds data words.
// Optional glitch filter on the synchronized line is compiled in with MSL_RX_GLITCH_FILTER_EN.
module msl_slave_receiver #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_CLK_FREQ   = 50_000_000,
  parameter int unsigned P_FILT_LEN   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_msl_sda,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic                    o_valid,
  output logic                    o_err,
  output logic [1:0]              o_err_code,
  output logic                    o_busy
);

  localparam int unsigned Unit     = P_CLK_FREQ / 1000;
  localparam logic [31:0] ShortMin = 32'(3 * Unit);
  localparam logic [31:0] LongMin  = 32'((15 * Unit) / 2);
  localparam logic [31:0] LongMax  = 32'(13 * Unit);
  localparam logic [31:0] Timeout  = 32'(13 * Unit + 1);
  localparam logic [31:0] HuntLen  = 32'(20 * Unit);
  localparam int unsigned CntW     = $clog2(P_DATA_WIDTH + 1);

  if (P_DATA_WIDTH % 2 != 0 || P_DATA_WIDTH < 2) begin : g_width_check
    $error("P_DATA_WIDTH must be even and at least 2");
  end

  typedef enum logic [2:0] {StHunt, StIdle, StStartL, StStartH, StData, StStopL} state_e;

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q, prev_q, lvl, line_edge;
  logic [31:0]             seg_cnt_q;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [P_DATA_WIDTH-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                    valid_q, valid_d, err_q, err_d;
  logic [1:0]              code_q, code_d;
  logic                    seg_long;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_msl_sda;
      sync2_q <= sync1_q;
    end
  end

`ifdef MSL_RX_GLITCH_FILTER_EN
  localparam int unsigned FiltW = $clog2(P_FILT_LEN + 1);
  logic             filt_q;
  logic [FiltW-1:0] filt_cnt_q;

  // Level follows the synchronizer only after P_FILT_LEN consecutive differing cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FiltW'(P_FILT_LEN - 1)) begin
      filt_q     <= sync2_q;
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FiltW'(1);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign line_edge = lvl ^ prev_q;
  assign seg_long  = (seg_cnt_q >= LongMin);
  assign o_busy    = (state_q == StStartL) || (state_q == StStartH) ||
                     (state_q == StData)   || (state_q == StStopL);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    code_d    = 2'd0;
    unique case (state_q)
      StHunt: if (lvl && !line_edge && seg_cnt_q >= HuntLen) state_d = StIdle;
      StIdle: if (line_edge && !lvl) state_d = StStartL;
      default: begin
        if (line_edge) begin
          if (seg_cnt_q < ShortMin) begin
            err_d  = 1'b1;
            code_d = 2'd1;
          end else if (seg_cnt_q > LongMax) begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end else begin
            case (state_q)
              StStartL: begin
                if (seg_long) begin
                  err_d  = 1'b1;
                  code_d = 2'd3;
                end else begin
                  state_d = StStartH;
                end
              end
              StStartH: begin
                if (seg_long) begin
                  err_d  = 1'b1;
                  code_d = 2'd3;
                end else begin
                  bit_cnt_d = '0;
                  state_d   = StData;
                end
              end
              StData: begin
                shreg_d   = {shreg_q[P_DATA_WIDTH-2:0], seg_long};
                bit_cnt_d = bit_cnt_q + CntW'(1);
                if (bit_cnt_q == CntW'(P_DATA_WIDTH - 1)) state_d = StStopL;
              end
              StStopL: begin
                if (seg_long) begin
                  err_d  = 1'b1;
                  code_d = 2'd3;
                end else begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = StIdle;
                end
              end
              default: ;
            endcase
          end
        end else if (seg_cnt_q >= Timeout) begin
          // Segment already too long; flag it without waiting for the closing edge.
          err_d  = 1'b1;
          code_d = 2'd2;
        end
      end
    endcase
    if (err_d) state_d = StHunt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StHunt;
      prev_q    <= 1'b1;
      seg_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      prev_q    <= lvl;
      if (line_edge) seg_cnt_q <= 32'd1;
      else if (seg_cnt_q != 32'hFFFF_FFFF) seg_cnt_q <= seg_cnt_q + 32'd1;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;

endmodule

// File: tb/tb_msl_slave_receiver.sv
// Bench for msl_slave_receiver: directed and random frames checked against a segment-list model.
module tb_msl_slave_receiver;

  localparam int W        = 8;
  localparam int U        = 10;
  localparam int FiltLen  = 4;
  localparam int ShortMin = 3 * U;
  localparam int LongMin  = (15 * U) / 2;
  localparam int Tmo      = 13 * U + 1;
`ifdef MSL_RX_GLITCH_FILTER_EN
  localparam int FiltLat  = FiltLen;
`else
  localparam int FiltLat  = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sda = 1'b1;
  logic [W-1:0] o_data;
  logic         o_valid, o_err, o_busy;
  logic [1:0]   o_err_code;

  msl_slave_receiver #(
    .P_DATA_WIDTH(W),
    .P_CLK_FREQ  (10_000),
    .P_FILT_LEN  (FiltLen)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_msl_sda (sda),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_err     (o_err),
    .o_err_code(o_err_code),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_valid = 0, n_err = 0, n_both = 0, busy_cyc = 0, valid_cyc = 0, err_cyc = 0;
  logic [7:0] last_data = '0;
  logic [1:0] last_code = '0;

  always @(negedge clk) begin
    if (o_valid) begin
      n_valid++;
      last_data = o_data;
      valid_cyc = cyc;
    end
    if (o_err) begin
      n_err++;
      last_code = o_err_code;
      err_cyc = cyc;
    end
    if (o_valid && o_err) n_both++;
    if (o_busy) busy_cyc++;
  end

  int         tests = 0, fails = 0;
  int         segs[$];
  int         line[$];
  logic [7:0] good_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [7:0] d, input int sw, input int lw, input int stop_w);
    segs.delete();
    segs.push_back(sw);
    segs.push_back(sw);
    for (int i = W - 1; i >= 0; i--) segs.push_back(d[i] ? lw : sw);
    segs.push_back(stop_w);
  endtask

  // Walk the segments of one frame; kind 1 = good word, 2 = error. off = cycles from frame start.
  task automatic model(input int s[$], output int kind, output int val, output int off);
    int         t;
    logic [7:0] acc;
    t = 0;
    acc = '0;
    kind = 0;
    val = 0;
    off = 0;
    for (int i = 0; i < s.size(); i++) begin
      int w;
      w = s[i];
      if (w >= Tmo) begin
        kind = 2; val = 2; off = t + Tmo + 3;
        return;
      end
      if (w < ShortMin) begin
        kind = 2; val = 1; off = t + w + 3;
        return;
      end
      if ((i < 2 || i == W + 2) && w >= LongMin) begin
        kind = 2; val = 3; off = t + w + 3;
        return;
      end
      if (i >= 2 && i < W + 2) acc = {acc[6:0], w >= LongMin};
      t += w;
      if (i == W + 2) begin
        kind = 1; val = int'(acc); off = t + 3;
        return;
      end
    end
  endtask

  task automatic run_frame(input string tag, input int glitch_idx);
    int kind, val, off, nv0, ne0, nb0, bc0, c0;
    line = segs;
    if (glitch_idx >= 0) begin
      int w, h;
      w = line[glitch_idx];
      h = (w - 2) / 2;
      line[glitch_idx] = h;
      line.insert(glitch_idx + 1, 2);
      line.insert(glitch_idx + 2, w - 2 - h);
    end
`ifdef MSL_RX_GLITCH_FILTER_EN
    model(segs, kind, val, off);
`else
    model(line, kind, val, off);
`endif
    nv0 = n_valid; ne0 = n_err; nb0 = n_both; bc0 = busy_cyc;
    @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < line.size(); i++) begin
      sda = (i % 2 == 1);
      repeat (line[i]) @(posedge clk);
      #1;
    end
    sda = 1'b1;
    repeat (26 * U) @(posedge clk);
    #1;
    check({tag, ".both"}, n_both - nb0, 0);
    if (kind == 1) begin
      check({tag, ".nvalid"}, n_valid - nv0, 1);
      check({tag, ".nerr"}, n_err - ne0, 0);
      check({tag, ".data"}, o_data, val);
      check({tag, ".vdata"}, last_data, val);
      check({tag, ".vcyc"}, valid_cyc, c0 + off + FiltLat);
      check({tag, ".busy"}, busy_cyc - bc0, off - 3);
      good_data = 8'(val);
    end else begin
      check({tag, ".nerr"}, n_err - ne0, 1);
      check({tag, ".nvalid"}, n_valid - nv0, 0);
      check({tag, ".code"}, last_code, val);
      check({tag, ".ecyc"}, err_cyc, c0 + off + FiltLat);
      check({tag, ".hold"}, o_data, good_data);
    end
    check({tag, ".idle"}, o_busy, 1'b0);
  endtask

  initial begin
    int nv0, ne0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.data", o_data, 0);
    check("rst.valid", o_valid, 0);
    check("rst.err", o_err, 0);
    check("rst.code", o_err_code, 0);
    check("rst.busy", o_busy, 0);
    rst_n = 1'b1;
    repeat (25 * U) @(posedge clk);
    #1;

    build(8'hA5, 5 * U, 10 * U, 6 * U);
    run_frame("a5", -1);
    build(8'h00, 5 * U, 10 * U, 6 * U);
    run_frame("f00", -1);
    build(8'hFF, 5 * U, 10 * U, 6 * U);
    run_frame("fff", -1);
    build(8'h3C, 5 * U, 10 * U, 6 * U);
    segs[4] = 2 * U;
    run_frame("short", -1);
    build(8'h5A, 5 * U, 10 * U, 6 * U);
    run_frame("f5a", -1);
    build(8'h81, 5 * U, 10 * U, 6 * U);
    segs[2] = 14 * U;
    run_frame("tmo", -1);
    build(8'h66, 5 * U, 10 * U, 6 * U);
    segs[0] = 10 * U;
    run_frame("frm", -1);
    build(8'hC3, ShortMin, 13 * U, 7 * U);
    run_frame("edge_lo", -1);
    build(8'h3C, LongMin - 1, LongMin, LongMin - 1);
    run_frame("edge_hi", -1);
    build(8'h99, 5 * U, 10 * U, 6 * U);
    segs[5] = ShortMin - 1;
    run_frame("short29", -1);

    // Reset in the middle of bit 4 discards the partial frame.
    build(8'h96, 5 * U, 10 * U, 6 * U);
    nv0 = n_valid;
    ne0 = n_err;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      sda = (i % 2 == 1);
      repeat (segs[i]) @(posedge clk);
      #1;
    end
    sda = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst.data", o_data, 0);
    check("mrst.valid", o_valid, 0);
    check("mrst.err", o_err, 0);
    check("mrst.code", o_err_code, 0);
    check("mrst.busy", o_busy, 0);
    sda = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    good_data = '0;
    repeat (25 * U) @(posedge clk);
    #1;
    check("mrst.nvalid", n_valid - nv0, 0);
    check("mrst.nerr", n_err - ne0, 0);
    build(8'h96, 5 * U, 10 * U, 6 * U);
    run_frame("after_rst", -1);

    build(8'hA5, 5 * U, 10 * U, 6 * U);
    run_frame("glitch", 7);

    for (int n = 0; n < 10; n++) begin
      logic [7:0] d;
      int         mode, idx;
      d = 8'($urandom);
      build(d, $urandom_range(LongMin - 1, ShortMin), $urandom_range(13 * U, LongMin),
            $urandom_range(LongMin - 1, ShortMin));
      mode = $urandom_range(0, 3);
      idx = $urandom_range(0, W + 2);
      if (mode == 1) segs[idx] = $urandom_range(ShortMin - 1, 10);
      if (mode == 2) segs[idx] = $urandom_range(150, Tmo);
      if (mode == 3) begin
        idx = $urandom_range(0, 2);
        if (idx == 2) idx = W + 2;
        segs[idx] = $urandom_range(13 * U, LongMin);
      end
      run_frame($sformatf("rnd%0d", n), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
